// File: rtl/mux4x1_scan_ctrl_pkg.sv
// Shared types and helpers for the 4:1 mux scan controller.
// The optional MUX_SCAN_CONTINUOUS_EN build uses the same definitions.
package mux4x1_scan_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSettle = 2'd1,
    StSample = 2'd2,
    StDone   = 2'd3
  } scan_state_e;

  localparam int unsigned NumCh = 4;

  // Wide enough to hold 0..dwell.
  function automatic int unsigned cnt_width(input int unsigned dwell);
    return $clog2(dwell + 1);
  endfunction

endpackage

// File: rtl/mux4x1_scan_ctrl_dwell_cnt.sv
// Settle counter: counts enabled cycles and flags the last one of each dwell window.
// The counter wraps to zero when it reaches that last cycle.
module scan_dwell_cnt
  import mux4x1_scan_ctrl_pkg::*;
#(
  parameter int unsigned DWELL = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int unsigned CntW = cnt_width(DWELL);
  localparam logic [CntW-1:0] LastCnt = CntW'(DWELL - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tc = (cnt_q == LastCnt);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tc ? '0 : cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mux4x1_scan_ctrl.sv
// Steps the mux selects through channels 0..3, samples f after a settle time, and
// presents the four samples as a parallel word. Define MUX_SCAN_CONTINUOUS_EN for free-running scans.
module mux4x1_scan_ctrl
  import mux4x1_scan_ctrl_pkg::*;
#(
  parameter int unsigned DWELL = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       f,
`ifdef MUX_SCAN_CONTINUOUS_EN
  input  logic       stop,
`endif
  output logic       sel0,
  output logic       sel1,
  output logic       busy,
  output logic [3:0] data,
  output logic       done
);

  localparam logic [1:0] LastCh = 2'(NumCh - 1);

  if (DWELL < 1 || DWELL > 255) begin : g_bad_dwell
    $error("mux4x1_scan_ctrl: DWELL must be in 1..255");
  end

  scan_state_e state_q, state_d;
  logic [1:0]  ch_q, ch_d;
  logic [2:0]  shadow_q, shadow_d;
  logic [3:0]  data_q, data_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        cnt_clr, cnt_en, cnt_tc;
  logic        stop_seen;

  scan_dwell_cnt #(
    .DWELL(DWELL)
  ) u_dwell_cnt (
    .clk(clk),
    .rst(rst),
    .clr(cnt_clr),
    .en (cnt_en),
    .tc (cnt_tc)
  );

`ifdef MUX_SCAN_CONTINUOUS_EN
  logic stop_q, stop_d;

  // A stop request anywhere outside idle is remembered until the scan finishes.
  always_comb begin
    stop_d = stop_q;
    if (state_q == StIdle) begin
      stop_d = 1'b0;
    end else if (stop) begin
      stop_d = 1'b1;
    end
  end

  assign stop_seen = stop_q | stop;
`else
  assign stop_seen = 1'b1;
`endif

  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    shadow_d = shadow_q;
    data_d   = data_q;
    cnt_clr  = 1'b0;
    cnt_en   = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_clr = 1'b1;
        ch_d    = '0;
        if (start) begin
          state_d = StSettle;
        end
      end
      StSettle: begin
        cnt_en = 1'b1;
        if (cnt_tc) begin
          state_d = StSample;
        end
      end
      StSample: begin
        unique case (ch_q)
          2'd0:    shadow_d[0] = f;
          2'd1:    shadow_d[1] = f;
          2'd2:    shadow_d[2] = f;
          default: ;
        endcase
        if (ch_q == LastCh) begin
          data_d  = {f, shadow_q};
          // Parking ch at 0 keeps the selects at 00 in DONE and IDLE.
          ch_d    = '0;
          state_d = StDone;
        end else begin
          ch_d    = ch_q + 2'd1;
          state_d = StSettle;
        end
      end
      StDone: begin
        cnt_clr = 1'b1;
        state_d = stop_seen ? StIdle : StSettle;
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d == StSettle) || (state_d == StSample);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      ch_q     <= '0;
      shadow_q <= '0;
      data_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef MUX_SCAN_CONTINUOUS_EN
      stop_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      shadow_q <= shadow_d;
      data_q   <= data_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef MUX_SCAN_CONTINUOUS_EN
      stop_q   <= stop_d;
`endif
    end
  end

  assign sel0 = ch_q[0];
  assign sel1 = ch_q[1];
  assign busy = busy_q;
  assign done = done_q;
  assign data = data_q;

endmodule

// File: doc/mux4x1_scan_ctrl.md
Name: mux4x1_scan_ctrl

Overview:
- Upstream/downstream companion to the 4:1 mux. It drives the mux select lines (sel0, sel1) through channels 0..3 in order.
- After each select change it waits a programmable settle time, then samples the mux output f.
- It assembles the four samples into a 4-bit word and flags completion with a one-cycle done pulse.
- Lets the gate-level mux be exercised and read as a 4-bit parallel input port.

Parameters:
- DWELL, 2, settle cycles held on each channel before sampling; legal range 1..255; DWELL=0 is an elaboration error.

Ports:
- clk  input  1  single system clock, rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request one scan; sampled only in IDLE
- f  input  1  mux output being scanned
- sel0  output  1  select LSB to mux
- sel1  output  1  select MSB to mux
- busy  output  1  high while a scan is in progress (SETTLE/SAMPLE)
- data  output  4  captured word; data[n] = f sampled with select = n
- done  output  1  one-cycle pulse when data updates

Behaviour:
- Clocking and reset:
  - One clock; reset is synchronous and active-high.
  - rst high at a clk edge forces: state=IDLE, ch=0, cnt=0, sel1/sel0=00, busy=0, done=0, data=4'b0000.
  - rst has priority over all other inputs, including mid-scan; a partial scan is discarded and data is not updated.
- sel1/sel0 are driven from the registered channel index ch only (glitch-free, no combinational path from start).
- States:
  - IDLE: sel=00, busy=0. If start=1 at an edge: ch<=0, cnt<=0, go to SETTLE.
  - SETTLE: busy=1, sel=ch. cnt increments each edge. When cnt==DWELL-1, cnt<=0 and go to SAMPLE.
  - SAMPLE: busy=1, sel=ch. At the edge, shadow[ch]<=f.
    - If ch==3: data<={f, shadow[2:0]}, go to DONE.
    - Else: ch<=ch+1, go to SETTLE.
  - DONE: busy=0, done=1 for exactly one cycle, sel=00. Next state is IDLE.
- Timing:
  - If start is accepted at edge E0, done is high in the cycle following edge E0+4*(DWELL+1).
  - With DWELL=2 that is 12 edges.
- Input handling:
  - start while busy or in DONE is ignored (not queued).
  - start held continuously launches a new scan from the IDLE cycle after DONE.
- data holds its value between scans; it changes only on entry to DONE (or on reset).
- cnt width is $clog2(DWELL+1). ch is 2 bits and never wraps within a scan.

Optional Feature:
- Macro: MUX_SCAN_CONTINUOUS_EN.
- Defined:
  - After DONE, go directly to SETTLE with ch=0, skipping IDLE; start is needed only for the first scan.
  - Add input stop (1 bit). stop=1 at any edge outside IDLE finishes the current scan normally, then returns to IDLE.
  - done pulses once per completed scan; back-to-back scan period is 4*(DWELL+1)+1 cycles.
- Undefined: no stop port; single-shot behaviour as specified above.

Decomposition:
- Shared package/header holds:
  - state encodings: IDLE=2'd0, SETTLE=2'd1, SAMPLE=2'd2, DONE=2'd3
  - NUM_CH=4
  - function for counter width
- One natural sub-module, scan_dwell_cnt: parameterised DWELL counter with clear input and a terminal-count output. FSM, channel register and shadow/data registers stay in the top level.

Test Plan:
- Reset check: rst=1 for 2 cycles with start=1 -> data=0000, done=0, busy=0, sel=00 throughout.
- Static pattern: bench models the mux with inputs i0..i3=1,0,1,1; pulse start with DWELL=2 -> sel steps 00,01,10,11 (3 cycles each); done pulses 12 edges after start; data=4'b1101.
- Settle check: bench drives f=X during the first DWELL-1 cycles of each channel and the true value only in the last SETTLE cycle and the SAMPLE cycle -> data still correct (1101). Also assert done width is exactly 1 and busy drops in the DONE cycle.
- Start while busy: pulse start again at cycle 5 of a scan -> no restart, a single done; pattern 0110 captured as 0110.
- Reset mid-scan: assert rst in channel-2 SETTLE after a prior scan produced 1111 -> data=0000 and IDLE next cycle. A new start with pattern 1010 -> data=1010.
- With MUX_SCAN_CONTINUOUS_EN: start once, patterns 0001 then 1000 -> done pulses 13 cycles apart, data 0001 then 1000. stop=1 during the second scan -> exactly two done pulses, then IDLE.
